// File: rtl/counter_pkg.sv
// Shared constants for the up/down event counter family.
// Mode values are meant to be used for the SATURATE parameter.
package counter_pkg;

    localparam int CNT_WRAP      = 0;
    localparam int CNT_SAT       = 1;
    localparam int CNT_W_DEFAULT = 4;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one-cycle pulse when a goes 0->1 between samples.
// a_q keeps tracking a while in reset, so a level held across reset release is not an edge.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic pulse
);

    logic a_q;

    // a_q follows a whether or not reset is asserted.
    always_ff @(posedge clk) begin
        a_q <= a;
    end

    // The pulse is suppressed during reset, so a consumer sees no event on a reset edge.
    assign pulse = rst & a & ~a_q;

endmodule

// File: rtl/counter_updown_mod.sv
// N-bit up/down event counter over the range 0..limit.
// It supports load, wrap or saturate behaviour, a terminal-count pulse and a sticky overflow flag.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int N        = CNT_W_DEFAULT,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] loadValue,
    input  logic [N-1:0] initValue,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf
);

    localparam bit SAT_MODE = (SATURATE == CNT_SAT);

    logic         pulse;
    logic [N-1:0] count_reg, count_next;
    logic         tc_reg, tc_next;
    logic         ovf_reg, ovf_next;

    function automatic logic [N-1:0] clamp(input logic [N-1:0] v, input logic [N-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    edge_detect_rise u_edge (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .pulse (pulse)
    );

    // Range checks happen before the +/-1, so 2^N rollover never decides the result.
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        ovf_next   = ovf_reg;
        if (load) begin
            count_next = clamp(loadValue, limit);
            ovf_next   = 1'b0;
        end else if (pulse) begin
            if (up) begin
                if (count_reg < limit) begin
                    count_next = count_reg + 1'b1;
                end else begin
                    // count >= limit also covers a limit that was lowered below count.
                    count_next = SAT_MODE ? limit : '0;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end
            end else begin
                if (count_reg != '0) begin
                    count_next = clamp(count_reg - 1'b1, limit);
                end else begin
                    count_next = SAT_MODE ? '0 : limit;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= clamp(initValue, limit);
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: instance 0 wraps, instance 1 saturates. The driver queues hand-computed
// expectations after each edge, and a monitor checks them on the following falling edge.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst_i  [2];
    logic       a_i    [2];
    logic       up_i   [2];
    logic       load_i [2];
    logic [3:0] lv_i   [2];
    logic [3:0] iv_i   [2];
    logic [3:0] lim_i  [2];
    logic [3:0] cnt_o  [2];
    logic       tc_o   [2];
    logic       ovf_o  [2];

    typedef struct {
        int         d;
        string      nm;
        logic [3:0] c;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.N(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst_i[0]), .a(a_i[0]), .up(up_i[0]), .load(load_i[0]),
        .loadValue(lv_i[0]), .initValue(iv_i[0]), .limit(lim_i[0]),
        .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
    );

    counter_updown_mod #(.N(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst_i[1]), .a(a_i[1]), .up(up_i[1]), .load(load_i[1]),
        .loadValue(lv_i[1]), .initValue(iv_i[1]), .limit(lim_i[1]),
        .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
    );

    // Monitor: DUT outputs are registered, so every queued expectation is checked at the next falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (cnt_o[e.d] !== e.c || tc_o[e.d] !== e.tc || ovf_o[e.d] !== e.ovf) begin
                n_fail++;
                $display("FAIL %s dut%0d: got count=%0d tc=%0b ovf=%0b, expected count=%0d tc=%0b ovf=%0b",
                         e.nm, e.d, cnt_o[e.d], tc_o[e.d], ovf_o[e.d], e.c, e.tc, e.ovf);
            end else begin
                $display("ok   %s dut%0d: count=%0d tc=%0b ovf=%0b", e.nm, e.d, cnt_o[e.d], tc_o[e.d], ovf_o[e.d]);
            end
        end
    end

    task automatic step(input int d, input logic r, input logic aa, input logic u, input logic ld,
                        input logic [3:0] lv, input logic [3:0] iv, input logic [3:0] lim,
                        input string nm, input logic [3:0] ec, input logic etc, input logic eovf);
        exp_t e;
        rst_i[d]  = r;
        a_i[d]    = aa;
        up_i[d]   = u;
        load_i[d] = ld;
        lv_i[d]   = lv;
        iv_i[d]   = iv;
        lim_i[d]  = lim;
        @(posedge clk);
        e.d = d; e.nm = nm; e.c = ec; e.tc = etc; e.ovf = eovf;
        sb.push_back(e);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b0; a_i[i] = 1'b0; up_i[i] = 1'b1; load_i[i] = 1'b0;
            lv_i[i] = '0; iv_i[i] = '0; lim_i[i] = '0;
        end
        @(negedge clk);

        // Wrap instance, limit 15
        //   d  rst a  up ld lv iv lim  name             cnt tc ovf
        step(0, 0, 0, 1, 0, 0, 9, 15, "reset_init9",     9,  0, 0);
        step(0, 1, 1, 1, 0, 0, 9, 15, "up_pulse1",       10, 0, 0);
        step(0, 1, 0, 1, 0, 0, 9, 15, "a_low",           10, 0, 0);
        step(0, 1, 1, 1, 0, 0, 9, 15, "up_pulse2",       11, 0, 0);
        step(0, 1, 0, 1, 0, 0, 9, 15, "a_low",           11, 0, 0);
        step(0, 1, 1, 1, 0, 0, 9, 15, "up_pulse3",       12, 0, 0);
        step(0, 1, 0, 1, 1, 14, 9, 15, "load14",         14, 0, 0);
        step(0, 1, 1, 1, 0, 0, 9, 15, "up_to_limit",     15, 0, 0);
        step(0, 1, 0, 1, 0, 0, 9, 15, "a_low",           15, 0, 0);
        step(0, 1, 1, 1, 0, 0, 9, 15, "wrap_to_0",       0,  1, 1);
        step(0, 1, 0, 1, 0, 0, 9, 15, "tc_one_cycle",    0,  0, 1);
        step(0, 1, 0, 1, 1, 3, 9, 15, "load3_clr_ovf",   3,  0, 0);
        step(0, 1, 1, 1, 1, 6, 9, 15, "load_beats_evt",  6,  0, 0);
        step(0, 1, 0, 1, 0, 0, 9, 15, "a_low",           6,  0, 0);
        step(0, 1, 1, 1, 0, 0, 9, 15, "held_hi_1",       7,  0, 0);
        for (int k = 2; k <= 5; k++)
            step(0, 1, 1, 1, 0, 0, 9, 15, "held_hi_n",   7,  0, 0);
        step(0, 0, 1, 1, 0, 0, 3, 15, "rst_mid_count",   3,  0, 0);
        step(0, 1, 1, 1, 0, 0, 3, 15, "a_hi_thru_rst",   3,  0, 0);
        step(0, 1, 0, 1, 0, 0, 3, 15, "a_low",           3,  0, 0);
        step(0, 1, 1, 1, 0, 0, 3, 15, "first_evt",       4,  0, 0);
        step(0, 0, 0, 1, 0, 0, 12, 5, "rst_clamp_init", 5,  0, 0);
        step(0, 1, 0, 1, 0, 0, 12, 2, "limit_lowered",  5,  0, 0);
        step(0, 1, 1, 1, 0, 0, 12, 2, "up_above_limit", 0,  1, 1);
        step(0, 1, 0, 0, 0, 0, 12, 2, "a_low",          0,  0, 1);
        step(0, 1, 1, 0, 0, 0, 12, 2, "down_wrap",      2,  1, 1);

        // Saturate instance, limit 10
        step(1, 0, 0, 0, 0, 0, 1, 10, "sat_reset1",      1,  0, 0);
        step(1, 1, 1, 0, 0, 0, 1, 10, "sat_down1",       0,  0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 10, "a_low",           0,  0, 0);
        step(1, 1, 1, 0, 0, 0, 1, 10, "sat_down2",       0,  1, 1);
        step(1, 1, 0, 0, 0, 0, 1, 10, "a_low",           0,  0, 1);
        step(1, 1, 1, 0, 0, 0, 1, 10, "sat_down3",       0,  1, 1);
        step(1, 1, 0, 1, 1, 10, 1, 10, "sat_load10",     10, 0, 0);
        step(1, 1, 1, 1, 0, 0, 1, 10, "sat_up_hold",     10, 1, 1);
        step(1, 1, 0, 1, 0, 0, 1, 10, "a_low",           10, 0, 1);
        step(1, 1, 0, 1, 1, 9, 1, 10, "sat_load9",       9,  0, 0);
        step(1, 1, 1, 0, 0, 0, 1, 4,  "down_clamp_lim",  4,  0, 0);
        step(1, 1, 0, 1, 1, 13, 1, 4, "load_clamped",    4,  0, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
